// File: rtl/rice_core_pkg.sv
// Shared definitions for the rice core CSR slice: CSR address map,
// mstatus field positions and the misa constant.
package rice_core_pkg;

  typedef enum logic [11:0] {
    CSR_MSTATUS   = 12'h300,
    CSR_MISA      = 12'h301,
    CSR_MTVEC     = 12'h305,
    CSR_MSCRATCH  = 12'h340,
    CSR_MEPC      = 12'h341,
    CSR_MCAUSE    = 12'h342,
    CSR_MTVAL     = 12'h343,
    CSR_MCYCLE    = 12'hB00,
    CSR_MINSTRET  = 12'hB02,
    CSR_MCYCLEH   = 12'hB80,
    CSR_MINSTRETH = 12'hB82,
    CSR_CYCLE     = 12'hC00,
    CSR_INSTRET   = 12'hC02,
    CSR_CYCLEH    = 12'hC80,
    CSR_INSTRETH  = 12'hC82,
    CSR_MHARTID   = 12'hF14
  } rice_core_csr_address;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // MXL sits in the top two bits of misa; only the base integer ISA is reported.
  function automatic logic [63:0] misa_value(input int xlen);
    logic [63:0] v;
    v = 64'h0000_0000_0000_0100;
    if (xlen == 64) v[63:62] = 2'd2;
    else            v[31:30] = 2'd1;
    return v;
  endfunction

endpackage

// File: rtl/rice_bus_if.sv
// CSR bus between the core's CSR read/write unit (master) and the CSR file (slave).
interface rice_bus_if #(
  parameter int XLEN = 32
);
  logic              request_valid;
  logic              request_ready;
  logic [11:0]       address;
  logic [XLEN/8-1:0] strobe;
  logic [XLEN-1:0]   write_data;
  logic              response_valid;
  logic              response_ready;
  logic [XLEN-1:0]   read_data;
  logic              error;

  modport master (
    output request_valid, address, strobe, write_data, response_ready,
    input  request_ready, response_valid, read_data, error
  );

  modport slave (
    input  request_valid, address, strobe, write_data, response_ready,
    output request_ready, response_valid, read_data, error
  );
endinterface

// File: rtl/rice_core_csr_counter.sv
// 64-bit free-running counter with per-half write; a write to a half
// overrides the increment for that half in the same cycle.
module rice_core_csr_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] data_lo,
  input  logic [31:0] data_hi,
  output logic [63:0] value
);
  logic [63:0] next_p0;

  assign next_p0 = value + 64'(inc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= '0;
    end else begin
      value[31:0]  <= wr_lo ? data_lo : next_p0[31:0];
      value[63:32] <= wr_hi ? data_hi : next_p0[63:32];
    end
  end
endmodule

// File: rtl/rice_core_csr_file.sv
// Machine-mode CSR file and single-outstanding CSR bus slave.
// Optional counters (mcycle/minstret and shadows) enabled by RICE_CORE_CSR_COUNTER_EN.
module rice_core_csr_file
  import rice_core_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] MTVEC_INIT = '0,
  parameter logic [XLEN-1:0] HART_ID    = '0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_retire,
  output logic [XLEN-1:0] o_mtvec,
  output logic [XLEN-1:0] o_mepc,
  output logic            o_mie,
  rice_bus_if.slave       csr_if
);
  logic            mie, mpie;
  logic [XLEN-1:0] mtvec, mscratch, mepc, mcause, mtval;
  logic [XLEN-1:0] rd_val, merged;
  logic            hit, is_write, err, ack, do_write;

  function automatic logic [XLEN-1:0] byte_merge(input logic [XLEN-1:0] old_d,
                                                 input logic [XLEN-1:0] new_d,
                                                 input logic [XLEN/8-1:0] strb);
    logic [XLEN-1:0] r;
    r = old_d;
    for (int i = 0; i < XLEN/8; i++)
      if (strb[i]) r[8*i +: 8] = new_d[8*i +: 8];
    return r;
  endfunction

`ifdef RICE_CORE_CSR_COUNTER_EN
  logic [63:0] cycle_val, instret_val, cnt_wdata;
  logic [31:0] cnt_lo, cnt_hi;
  logic        cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;

  // On XLEN=32 the *h addresses carry the high half in the low XLEN bits.
  assign cnt_wdata = 64'(merged);
  assign cnt_lo    = cnt_wdata[31:0];
  assign cnt_hi    = (XLEN == 64) ? cnt_wdata[63:32] : cnt_wdata[31:0];
  assign cyc_wr_lo = do_write && (csr_if.address == CSR_MCYCLE);
  assign cyc_wr_hi = do_write && ((csr_if.address == CSR_MCYCLE && XLEN == 64) ||
                                  csr_if.address == CSR_MCYCLEH);
  assign ins_wr_lo = do_write && (csr_if.address == CSR_MINSTRET);
  assign ins_wr_hi = do_write && ((csr_if.address == CSR_MINSTRET && XLEN == 64) ||
                                  csr_if.address == CSR_MINSTRETH);

  rice_core_csr_counter u_mcycle (
    .clk(i_clk), .rst_n(i_rst_n), .inc(1'b1),
    .wr_lo(cyc_wr_lo), .wr_hi(cyc_wr_hi), .data_lo(cnt_lo), .data_hi(cnt_hi),
    .value(cycle_val)
  );

  rice_core_csr_counter u_minstret (
    .clk(i_clk), .rst_n(i_rst_n), .inc(i_retire),
    .wr_lo(ins_wr_lo), .wr_hi(ins_wr_hi), .data_lo(cnt_lo), .data_hi(cnt_hi),
    .value(instret_val)
  );
`else
  logic unused_retire;
  assign unused_retire = i_retire;
`endif

  always_comb begin
    rd_val = '0;
    hit    = 1'b1;
    case (csr_if.address)
      CSR_MSTATUS: begin
        rd_val[MSTATUS_MIE]                   = mie;
        rd_val[MSTATUS_MPIE]                  = mpie;
        rd_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      CSR_MISA:     rd_val = XLEN'(misa_value(XLEN));
      CSR_MTVEC:    rd_val = mtvec;
      CSR_MSCRATCH: rd_val = mscratch;
      CSR_MEPC:     rd_val = mepc;
      CSR_MCAUSE:   rd_val = mcause;
      CSR_MTVAL:    rd_val = mtval;
      CSR_MHARTID:  rd_val = HART_ID;
`ifdef RICE_CORE_CSR_COUNTER_EN
      CSR_MCYCLE,   CSR_CYCLE:   rd_val = cycle_val[XLEN-1:0];
      CSR_MINSTRET, CSR_INSTRET: rd_val = instret_val[XLEN-1:0];
      CSR_MCYCLEH,  CSR_CYCLEH: begin
        if (XLEN == 32) rd_val = XLEN'(cycle_val[63:32]);
        else            hit    = 1'b0;
      end
      CSR_MINSTRETH, CSR_INSTRETH: begin
        if (XLEN == 32) rd_val = XLEN'(instret_val[63:32]);
        else            hit    = 1'b0;
      end
`endif
      default: hit = 1'b0;
    endcase
  end

  assign is_write = |csr_if.strobe;
  assign err      = !hit || (is_write && csr_if.address[11:10] == 2'b11);
  assign ack      = csr_if.request_valid && csr_if.request_ready;
  assign do_write = ack && is_write && !err;
  assign merged   = byte_merge(rd_val, csr_if.write_data, csr_if.strobe);

  assign csr_if.request_ready = !csr_if.response_valid;
  assign o_mtvec = mtvec;
  assign o_mepc  = mepc;
  assign o_mie   = mie;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      csr_if.response_valid <= 1'b0;
      csr_if.read_data      <= '0;
      csr_if.error          <= 1'b0;
    end else if (ack) begin
      csr_if.response_valid <= 1'b1;
      csr_if.read_data      <= err ? '0 : rd_val;
      csr_if.error          <= err;
    end else if (csr_if.response_valid && csr_if.response_ready) begin
      csr_if.response_valid <= 1'b0;
      csr_if.read_data      <= '0;
      csr_if.error          <= 1'b0;
    end
  end

  // mtvec modes 2 and 3 are reserved, so such writes keep the previous mode.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= MTVEC_INIT;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
    end else if (do_write) begin
      case (csr_if.address)
        CSR_MSTATUS: begin
          mie  <= merged[MSTATUS_MIE];
          mpie <= merged[MSTATUS_MPIE];
        end
        CSR_MTVEC:    mtvec    <= {merged[XLEN-1:2], merged[1] ? mtvec[1:0] : merged[1:0]};
        CSR_MSCRATCH: mscratch <= merged;
        CSR_MEPC:     mepc     <= {merged[XLEN-1:2], 2'b00};
        CSR_MCAUSE:   mcause   <= merged;
        CSR_MTVAL:    mtval    <= merged;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rice_core_csr_file.sv
// Directed self-checking bench for rice_core_csr_file (XLEN=32).
module tb_rice_core_csr_file;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        retire = 1'b0;
  logic [31:0] mtvec, mepc;
  logic        mie;
  int          checks = 0;
  int          errors = 0;

  rice_bus_if #(.XLEN(32)) bif ();

  rice_core_csr_file #(
    .XLEN(32), .MTVEC_INIT(32'h8000_0000), .HART_ID(32'h0000_0007)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_retire(retire),
    .o_mtvec(mtvec), .o_mepc(mepc), .o_mie(mie), .csr_if(bif)
  );

  always #5 clk = ~clk;

  // One full transaction with response_ready=1; lat_ok means response_valid
  // was seen exactly one cycle after the accepting edge.
  task automatic bus(input logic [11:0] a, input logic [3:0] s, input logic [31:0] d,
                     output logic [31:0] rd, output logic e, output logic lat_ok);
    int n = 0;
    bif.request_valid = 1'b1;
    bif.address       = a;
    bif.strobe        = s;
    bif.write_data    = d;
    while (!bif.request_ready && n < 10) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    bif.request_valid = 1'b0;
    bif.strobe        = '0;
    lat_ok = bif.response_valid && (n < 10);
    rd     = bif.read_data;
    e      = bif.error;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic e, ok;
    bif.request_valid = 0; bif.address = '0; bif.strobe = '0;
    bif.write_data = '0; bif.response_ready = 1;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bif.response_valid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0", bif.response_valid); end
    checks++; if (bif.read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bif.read_data); end
    checks++; if (bif.request_ready !== 1'b1) begin errors++; $display("FAIL reset_rready got=%b exp=1", bif.request_ready); end
    checks++; if (mtvec !== 32'h8000_0000) begin errors++; $display("FAIL reset_mtvec got=%h exp=80000000", mtvec); end
    checks++; if (mepc !== 32'h0 || mie !== 1'b0) begin errors++; $display("FAIL reset_mepc_mie got=%h/%b exp=0/0", mepc, mie); end
    rst_n = 1;
    @(posedge clk); #1;
    bus(12'h305, 4'h0, 32'h0, rd, e, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL read_latency got=%b exp=1", ok); end
    checks++; if (rd !== 32'h8000_0000 || e !== 1'b0) begin errors++; $display("FAIL mtvec_read got=%h/%b exp=80000000/0", rd, e); end
  endtask

  task automatic test_partial_write();
    logic [31:0] rd; logic e, ok;
    bus(12'h340, 4'b0101, 32'hDEAD_BEEF, rd, e, ok);
    checks++; if (rd !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL wr_mscratch_old got=%h/%b exp=0/0", rd, e); end
    bus(12'h340, 4'h0, 32'hFFFF_FFFF, rd, e, ok);
    checks++; if (rd !== 32'h00AD_00EF) begin errors++; $display("FAIL mscratch_merge got=%h exp=00ad00ef", rd); end
    bus(12'h343, 4'b1010, 32'h1122_3344, rd, e, ok);
    bus(12'h343, 4'h0, 32'h0, rd, e, ok);
    checks++; if (rd !== 32'h1100_3300) begin errors++; $display("FAIL mtval_merge got=%h exp=11003300", rd); end
  endtask

  task automatic test_warl();
    logic [31:0] rd; logic e, ok;
    bus(12'h305, 4'hF, 32'h1000_0003, rd, e, ok);
    checks++; if (rd !== 32'h8000_0000) begin errors++; $display("FAIL mtvec_old got=%h exp=80000000", rd); end
    bus(12'h305, 4'h0, 32'h0, rd, e, ok);
    checks++; if (rd !== 32'h1000_0000) begin errors++; $display("FAIL mtvec_mode_keep got=%h exp=10000000", rd); end
    checks++; if (mtvec !== 32'h1000_0000) begin errors++; $display("FAIL o_mtvec got=%h exp=10000000", mtvec); end
    bus(12'h305, 4'hF, 32'h2000_0001, rd, e, ok);
    bus(12'h305, 4'h0, 32'h0, rd, e, ok);
    checks++; if (rd !== 32'h2000_0001) begin errors++; $display("FAIL mtvec_vectored got=%h exp=20000001", rd); end
    bus(12'h341, 4'hF, 32'h0000_0123, rd, e, ok);
    bus(12'h341, 4'h0, 32'h0, rd, e, ok);
    checks++; if (rd !== 32'h0000_0120 || mepc !== 32'h0000_0120) begin errors++; $display("FAIL mepc_align got=%h/%h exp=00000120", rd, mepc); end
    // MPP always reads 2'b11 (0x1800) alongside the written MIE/MPIE.
    bus(12'h300, 4'hF, 32'hFFFF_FFFF, rd, e, ok);
    bus(12'h300, 4'h0, 32'h0, rd, e, ok);
    checks++; if (rd !== 32'h0000_1888 || mie !== 1'b1) begin errors++; $display("FAIL mstatus got=%h/%b exp=00001888/1", rd, mie); end
    bus(12'h301, 4'hF, 32'h0, rd, e, ok);
    checks++; if (rd !== 32'h4000_0100 || e !== 1'b0) begin errors++; $display("FAIL misa_write got=%h/%b exp=40000100/0", rd, e); end
    bus(12'h301, 4'h0, 32'h0, rd, e, ok);
    checks++; if (rd !== 32'h4000_0100) begin errors++; $display("FAIL misa_const got=%h exp=40000100", rd); end
    bus(12'hF14, 4'h0, 32'h0, rd, e, ok);
    checks++; if (rd !== 32'h7 || e !== 1'b0) begin errors++; $display("FAIL mhartid got=%h/%b exp=7/0", rd, e); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic e, ok;
    bus(12'hC00, 4'hF, 32'h1234_5678, rd, e, ok);
    checks++; if (rd !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL ro_write got=%h/%b exp=0/1", rd, e); end
    bus(12'h7C0, 4'h0, 32'h0, rd, e, ok);
    checks++; if (rd !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL unimpl_read got=%h/%b exp=0/1", rd, e); end
    bus(12'hF14, 4'hF, 32'h0, rd, e, ok);
    checks++; if (rd !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL hartid_write got=%h/%b exp=0/1", rd, e); end
    bus(12'h340, 4'h0, 32'h0, rd, e, ok);
    checks++; if (rd !== 32'h00AD_00EF) begin errors++; $display("FAIL err_no_change got=%h exp=00ad00ef", rd); end
  endtask

  task automatic test_backpressure();
    bif.response_ready = 0;
    bif.request_valid  = 1;
    bif.address        = 12'h340;
    bif.strobe         = '0;
    @(posedge clk); #1;
    // Keep a second request pending; it must not be accepted while stalled.
    bif.address = 12'h305;
    bif.strobe  = 4'hF;
    bif.write_data = 32'h0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bif.response_valid !== 1'b1 || bif.request_ready !== 1'b0) begin errors++; $display("FAIL hold_ctrl[%0d] got=%b/%b exp=1/0", i, bif.response_valid, bif.request_ready); end
      checks++; if (bif.read_data !== 32'h00AD_00EF || bif.error !== 1'b0) begin errors++; $display("FAIL hold_data[%0d] got=%h/%b exp=00ad00ef/0", i, bif.read_data, bif.error); end
      @(posedge clk); #1;
    end
    bif.request_valid  = 0;
    bif.strobe         = '0;
    bif.response_ready = 1;
    @(posedge clk); #1;
    checks++; if (bif.response_valid !== 1'b0 || bif.read_data !== 32'h0) begin errors++; $display("FAIL hold_release got=%b/%h exp=0/0", bif.response_valid, bif.read_data); end
    checks++; if (mtvec !== 32'h2000_0001) begin errors++; $display("FAIL stalled_write_leak got=%h exp=20000001", mtvec); end
  endtask

`ifdef RICE_CORE_CSR_COUNTER_EN
  task automatic test_counters();
    logic [31:0] rd; logic e, ok;
    bus(12'hB80, 4'hF, 32'h0, rd, e, ok);
    bus(12'hB00, 4'hF, 32'hFFFF_FFFF, rd, e, ok);
    repeat (3) @(posedge clk);
    #1;
    bus(12'hB80, 4'h0, 32'h0, rd, e, ok);
    checks++; if (rd !== 32'h1 || e !== 1'b0) begin errors++; $display("FAIL mcycleh_carry got=%h/%b exp=1/0", rd, e); end
    bus(12'hB02, 4'hF, 32'h0, rd, e, ok);
    for (int i = 0; i < 3; i++) begin
      retire = 1; @(posedge clk); #1; retire = 0; @(posedge clk); #1;
    end
    bus(12'hB02, 4'h0, 32'h0, rd, e, ok);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL minstret_3 got=%h exp=3", rd); end
    // retire is high at the write edge (write wins -> 5) and the following edge (+1).
    retire = 1;
    bus(12'hB02, 4'hF, 32'h5, rd, e, ok);
    retire = 0;
    retire = 1; @(posedge clk); #1; retire = 0;
    bus(12'hC02, 4'h0, 32'h0, rd, e, ok);
    checks++; if (rd !== 32'h7 || e !== 1'b0) begin errors++; $display("FAIL instret_shadow got=%h/%b exp=7/0", rd, e); end
    bus(12'hC82, 4'h0, 32'h0, rd, e, ok);
    checks++; if (rd !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL instreth got=%h/%b exp=0/0", rd, e); end
  endtask
`else
  task automatic test_no_counters();
    logic [31:0] rd; logic e, ok;
    bus(12'hB00, 4'h0, 32'h0, rd, e, ok);
    checks++; if (rd !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL mcycle_absent got=%h/%b exp=0/1", rd, e); end
    bus(12'hB82, 4'hF, 32'h1, rd, e, ok);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL minstreth_absent got=%b exp=1", e); end
    bus(12'hC00, 4'h0, 32'h0, rd, e, ok);
    checks++; if (rd !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL cycle_absent got=%h/%b exp=0/1", rd, e); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] rd; logic e, ok;
    bif.response_ready = 0;
    bif.request_valid  = 1;
    bif.address        = 12'h340;
    bif.strobe         = '0;
    @(posedge clk); #1;
    bif.request_valid = 0;
    checks++; if (bif.response_valid !== 1'b1) begin errors++; $display("FAIL mid_pending got=%b exp=1", bif.response_valid); end
    rst_n = 0;
    @(posedge clk); #1;
    checks++; if (bif.response_valid !== 1'b0 || bif.read_data !== 32'h0) begin errors++; $display("FAIL mid_reset_drop got=%b/%h exp=0/0", bif.response_valid, bif.read_data); end
    rst_n = 1;
    bif.response_ready = 1;
    bus(12'h340, 4'h0, 32'h0, rd, e, ok);
    checks++; if (rd !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL mscratch_after_reset got=%h/%b exp=0/0", rd, e); end
    bus(12'h305, 4'h0, 32'h0, rd, e, ok);
    checks++; if (rd !== 32'h8000_0000) begin errors++; $display("FAIL mtvec_after_reset got=%h exp=80000000", rd); end
  endtask

  initial begin
    test_reset();
    test_partial_write();
    test_warl();
    test_errors();
    test_backpressure();
`ifdef RICE_CORE_CSR_COUNTER_EN
    test_counters();
`else
    test_no_counters();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rice_core_csr_file.md
Name: rice_core_csr_file

Overview:
Machine-mode CSR storage and bus responder. Sits directly downstream of the core's CSR read/write unit, as the slave end of its CSR bus. Serves one transaction at a time: read, full/partial-byte write, or error. Also exports trap-related CSR values to the core and runs the cycle/instret counters.

Parameters:
XLEN, 32, data width; 32 or 64
MTVEC_INIT, 0, reset value of mtvec (XLEN bits)
HART_ID, 0, value returned by mhartid

Ports:
i_clk  input  1  clock
i_rst_n  input  1  reset; synchronous, active-low
i_retire  input  1  one instruction retired this cycle; increments minstret
o_mtvec  output  XLEN  current mtvec
o_mepc  output  XLEN  current mepc
o_mie  output  1  mstatus.MIE
csr_if  rice_bus_if.slave  -  request_valid/request_ready, address[11:0], strobe[XLEN/8], write_data, response_valid/response_ready, read_data, error

Behaviour:
- Reset (sync, i_rst_n low at posedge), all values below:
  - response_valid=0, read_data=0, error=0
  - mstatus.MIE/MPIE=0, mtvec=MTVEC_INIT, mscratch/mepc/mcause/mtval=0
  - mcycle/minstret=0
  - Reset mid-transaction drops the response.
- Single outstanding transaction: request_ready = !response_valid. request_ack = request_valid && request_ready.
- On request_ack, in the same cycle:
  - Decode the address.
  - Register read_data = the CSR value before any write.
  - Register error.
  - Set response_valid=1.
- Response latency: exactly 1 cycle after request_ack. read_data, error and response_valid are held stable until response_valid && response_ready. They clear at that edge unless a new request_ack occurs; a new request cannot be acked in the same cycle because request_ready=0.
- Write: strobe != 0. Byte-merge write_data into the CSR where strobe[i]=1. Takes effect at the request_ack edge.
- Error conditions (read_data=0, no state change):
  - unimplemented address
  - write to read-only space (address[11:10]==2'b11)
  - XLEN=64 access to the *h counter addresses
- Implemented CSRs:
  - mstatus 0x300: MIE[3] and MPIE[7] writable. MPP[12:11] reads 2'b11. All other bits read 0.
  - misa 0x301: read-only constant (MXL per XLEN, bit 8 'I'). Writes are ignored without error.
  - mtvec 0x305: WARL. A written mode of 2 or 3 keeps the old mode; the base always updates.
  - mscratch 0x340, mcause 0x342, mtval 0x343: full RW.
  - mepc 0x341: bits[1:0] hardwired 0.
  - mhartid 0xF14: returns HART_ID.
  - Counters: see Optional Feature.
- Counter update priority, per half: a bus write to that half wins over the increment in the same cycle. mcycle increments every cycle. minstret increments when i_retire=1. Both are 64-bit and wrap from all-ones to 0.
- Outputs o_mtvec, o_mepc, o_mie are combinational from the registers. They reflect a write from the cycle after request_ack.

Optional Feature:
RICE_CORE_CSR_COUNTER_EN
- Defined:
  - mcycle 0xB00 and minstret 0xB02 are RW (low XLEN bits).
  - mcycleh 0xB80 and minstreth 0xB82 are RW when XLEN=32.
  - cycle 0xC00, instret 0xC02, cycleh 0xC80, instreth 0xC82 are read-only shadows; cycleh/instreth exist only when XLEN=32.
- Undefined: no counter flops. All of the above addresses return error; i_retire is ignored.

Decomposition:
- rice_core_pkg gets:
  - rice_core_csr_address enum (12-bit) with all addresses above
  - mstatus bit-position constants
  - misa value function of XLEN
- Sub-module rice_core_csr_counter:
  - 64-bit counter with increment enable
  - per-half write enable and data
  - write-over-increment priority
  - instantiated twice

Test Plan:
1. Reset, then read 0x305 with MTVEC_INIT=0x8000_0000 -> response 1 cycle after request_ack, read_data=0x8000_0000, error=0.
2. Write 0x340 with data 0xDEAD_BEEF, strobe 4'b0101, prior value 0 -> later read returns 0x00AD_00EF.
3. Write mtvec 0x1000_0003 when old value is 0x0 -> read returns 0x1000_0000. Write mepc 0x123 -> read returns 0x120.
4. Write 0xC00 and read 0x7C0 -> each returns error=1, read_data=0, no state change. Hold response_ready=0 for 5 cycles -> response stays stable and request_ready=0 throughout.
5. With COUNTER_EN, XLEN=32:
   - write mcycle=0xFFFF_FFFF, mcycleh=0 -> mcycleh reads 1 a few cycles later.
   - i_retire pulsed 3 times with minstret=0 -> reads 3.
   - write minstret=5 in a retire cycle -> next read shows 5 + later retires.
6. Without COUNTER_EN: read 0xB00 -> error=1. Assert reset mid-response -> response_valid=0 on the next cycle and mscratch=0.
